// File: rtl/prng_range_gen.sv
// prng_range_gen: Galois LFSR with seed load, zero-lockup recovery and a
// req/valid/ack draw port that returns a value uniform in [RANGE_MIN, RANGE_MAX]
// by rejection sampling with a bounded retry count.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   enable_i      free-run step of the LFSR while idle
//   seed_load_i   load seed_in_i into the LFSR this cycle (0 maps to SEED)
//   seed_in_i     seed value
//   req_i         draw request, sampled only in IDLE
//   ack_i         consumer accepts value_o, sampled only in VALID
//   busy_o        high while a draw is in progress or its value is held
//   valid_o       value_o is valid; held until ack_i
//   value_o       drawn value, stable while valid_o
//   lfsr_out_o    current LFSR state
//   lockup_o      one-cycle pulse when an all-zero LFSR state is recovered
module prng_range_gen #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0]  SEED      = 16'hACE1,
    parameter int unsigned       OUT_W     = 8,
    parameter int unsigned       RANGE_MIN = 40,
    parameter int unsigned       RANGE_MAX = 167,
    parameter int unsigned       MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic             req_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [OUT_W-1:0] value_o,
    output logic [WIDTH-1:0] lfsr_out_o,
    output logic             lockup_o
);

    localparam int unsigned SPAN  = RANGE_MAX - RANGE_MIN + 1;
    localparam int unsigned TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [OUT_W-1:0] FALLBACK = OUT_W'(RANGE_MIN + (SPAN >> 1));

    // Elaboration-time parameter sanity checks
    if (SEED == '0) begin : g_bad_seed
        $error("prng_range_gen: SEED must be nonzero");
    end
    if (OUT_W > WIDTH) begin : g_bad_out_w
        $error("prng_range_gen: OUT_W must not exceed WIDTH");
    end
    if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("prng_range_gen: WIDTH must be in 8..32");
    end
    if (RANGE_MAX < RANGE_MIN || SPAN > (64'd1 << OUT_W)) begin : g_bad_span
        $error("prng_range_gen: SPAN must be in 1..2^OUT_W");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("prng_range_gen: MAX_TRIES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [OUT_W-1:0]   value_q, value_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               lockup_q, lockup_d;

    logic [WIDTH-1:0]   step_c;
    logic [OUT_W-1:0]   sample_c;
    logic [OUT_W:0]     sum_c;
    logic               unused_sum_msb;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            try_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            try_q    <= try_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            lockup_q <= lockup_d;
        end
    end

    // Next-state: LFSR update, draw FSM, registered flags
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        try_d    = try_q;
        value_d  = value_q;
        lockup_d = 1'b0;

        step_c         = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        sample_c       = lfsr_q[OUT_W-1:0];
        sum_c          = (OUT_W + 1)'(RANGE_MIN) + {1'b0, sample_c};
        unused_sum_msb = sum_c[OUT_W];

        // Seed load wins over lockup recovery, which wins over stepping
        if (seed_load_i) begin
            lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
        end else if (lfsr_q == '0) begin
            lfsr_d   = SEED;
            lockup_d = 1'b1;
        end else if (enable_i || state_q == ST_DRAW) begin
            lfsr_d = step_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_DRAW;
                    try_d   = '0;
                end
            end
            ST_DRAW: begin
                // Sample uses the pre-update LFSR, even on a seed load
                if (32'(sample_c) < SPAN) begin
                    value_d = sum_c[OUT_W-1:0];
                    state_d = ST_VALID;
                end else if ((32'(try_q) + 32'd1) == MAX_TRIES) begin
                    value_d = FALLBACK;
                    state_d = ST_VALID;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            ST_VALID: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_VALID);
        busy_d  = (state_d != ST_IDLE);
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign value_o    = value_q;
    assign lfsr_out_o = lfsr_q;
    assign lockup_o   = lockup_q;

endmodule

// File: tb/tb_prng_range_gen.sv
// tb_prng_range_gen: directed and randomized checks of prng_range_gen against
// an arithmetic reference model of the LFSR and the draw protocol.
module tb_prng_range_gen;

    localparam int unsigned SEED_V = 32'hACE1;
    localparam int unsigned TAPS_V = 32'hB400;
    localparam int unsigned RMIN   = 40;
    localparam int unsigned RMAX   = 167;
    localparam int unsigned NTRY   = 4;
    localparam int unsigned N_RND  = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic        ack;
    logic        busy, valid, lockup;
    logic [7:0]  value;
    logic [15:0] lfsr_out;
    logic        busy1, valid1, lockup1;
    logic [7:0]  value1;
    logic [15:0] lfsr_out1;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int m_lfsr;
    int m_phase;   // 0 waiting for req, 1 drawing, 2 holding a value
    int m_tries;
    int m_value;
    int m_lock;

    always #5 clk = ~clk;

    prng_range_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .seed_load_i (seed_load),
        .seed_in_i   (seed_in),
        .req_i       (req),
        .ack_i       (ack),
        .busy_o      (busy),
        .valid_o     (valid),
        .value_o     (value),
        .lfsr_out_o  (lfsr_out),
        .lockup_o    (lockup)
    );

    prng_range_gen #(.MAX_TRIES(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .seed_load_i (seed_load),
        .seed_in_i   (seed_in),
        .req_i       (req),
        .ack_i       (ack),
        .busy_o      (busy1),
        .valid_o     (valid1),
        .value_o     (value1),
        .lfsr_out_o  (lfsr_out1),
        .lockup_o    (lockup1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int lfsr_next(input int x);
        return (x % 2 == 1) ? ((x / 2) ^ TAPS_V) : (x / 2);
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_cycle();
        int s;
        bit was_drawing;
        if (reset) begin
            m_lfsr = SEED_V; m_phase = 0; m_tries = 0; m_value = 0; m_lock = 0;
            return;
        end
        s           = m_lfsr % 256;
        was_drawing = (m_phase == 1);
        m_lock      = 0;
        if (seed_load)            m_lfsr = (seed_in == 16'h0) ? SEED_V : int'(seed_in);
        else if (m_lfsr == 0)     begin m_lfsr = SEED_V; m_lock = 1; end
        else if (enable || was_drawing) m_lfsr = lfsr_next(m_lfsr);

        if (m_phase == 0) begin
            if (req) begin m_phase = 1; m_tries = 0; end
        end else if (m_phase == 1) begin
            if (s <= int'(RMAX - RMIN)) begin
                m_value = int'(RMIN) + s; m_phase = 2;
            end else if (m_tries + 1 >= int'(NTRY)) begin
                m_value = int'(RMIN) + int'((RMAX - RMIN + 1) / 2); m_phase = 2;
            end else begin
                m_tries++;
            end
        end else if (ack) begin
            m_phase = 0;
        end
    endtask

    initial begin
        int cnt;
        bit p_valid, p_ack, p_reset, p_zero;

        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0; ack = 1'b0;
        cyc(); cyc();
        reset = 1'b0;

        // Idle after reset
        repeat (3) cyc();
        check("rst_lfsr",  32'(lfsr_out), 32'hACE1);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_value", 32'(value), 0);
        check("rst_lock",  32'(lockup), 0);

        // Free-run stepping
        enable = 1'b1;
        cyc(); check("step1", 32'(lfsr_out), 32'hE270);
        cyc(); check("step2", 32'(lfsr_out), 32'h7138);
        enable = 1'b0;

        // Draw with one rejection; MAX_TRIES=1 instance falls back
        reset = 1'b1; cyc(); reset = 1'b0;
        req = 1'b1; cyc(); req = 1'b0;
        check("d_c1_busy",  32'(busy), 1);
        check("d_c1_valid", 32'(valid), 0);
        check("d_c1_lfsr",  32'(lfsr_out), 32'hACE1);
        cyc();
        check("d_c2_valid", 32'(valid), 0);
        check("d_c2_lfsr",  32'(lfsr_out), 32'hE270);
        check("fb_valid",   32'(valid1), 1);
        check("fb_value",   32'(value1), 104);
        cyc();
        check("d_c3_valid", 32'(valid), 1);
        check("d_c3_value", 32'(value), 152);
        check("d_c3_busy",  32'(busy), 1);
        repeat (3) cyc();
        check("hold_valid", 32'(valid), 1);
        check("hold_value", 32'(value), 152);
        check("hold_fb",    32'(value1), 104);
        req = 1'b1; ack = 1'b1; cyc(); req = 1'b0; ack = 1'b0;
        check("ack_valid", 32'(valid), 0);
        check("ack_busy",  32'(busy), 0);
        cyc();
        check("b2b_ignored", 32'(busy), 0);

        // Seed loading and zero-lockup recovery
        seed_load = 1'b1; seed_in = 16'h1234; cyc();
        check("seed_val", 32'(lfsr_out), 32'h1234);
        seed_in = 16'h0; cyc(); seed_load = 1'b0;
        check("seed_zero", 32'(lfsr_out), 32'hACE1);
        check("seed_nolock", 32'(lockup), 0);
        dut.lfsr_q = '0;
        cyc();
        check("lock_lfsr", 32'(lfsr_out), 32'hACE1);
        check("lock_pulse", 32'(lockup), 1);
        cyc();
        check("lock_end", 32'(lockup), 0);

        // Randomized run against the model
        reset = 1'b1; model_cycle(); cyc(); reset = 1'b0;
        p_valid = 1'b0; p_ack = 1'b0; p_reset = 1'b1; p_zero = 1'b0;
        for (int c = 0; c < int'(N_RND); c++) begin
            check("rnd_lfsr",  32'(lfsr_out), 32'(m_lfsr));
            check("rnd_valid", 32'(valid), 32'(m_phase == 2));
            check("rnd_busy",  32'(busy), 32'(m_phase != 0));
            check("rnd_value", 32'(value), 32'(m_value));
            check("rnd_lock",  32'(lockup), 32'(m_lock));
            if (valid) check("rnd_range", 32'(value >= 8'(RMIN) && value <= 8'(RMAX)), 1);
            if (p_valid && !p_ack && !p_reset) check("rnd_nodrop", 32'(valid), 1);
            check("rnd_zero2", 32'(p_zero && lfsr_out == 16'h0), 0);
            p_valid = valid; p_zero = (lfsr_out == 16'h0);

            reset     = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 1) == 1);
            req       = ($urandom_range(0, 9) < 3);
            ack       = ($urandom_range(0, 9) < 3);
            seed_load = ($urandom_range(0, 29) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                dut.lfsr_q = '0;
                m_lfsr = 0;
            end
            p_ack = ack; p_reset = reset;
            model_cycle();
            cyc();
        end
        reset = 1'b0; req = 1'b0; ack = 1'b0; seed_load = 1'b0;

        // Full period with enable held high
        reset = 1'b1; cyc(); reset = 1'b0; enable = 1'b1;
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (lfsr_out != 16'hACE1 && cnt < 70000);
        check("period", 32'(cnt), 65535);
        enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
